// File: rtl/gear_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gear_window_buffer
// Desc     : Row ring buffer that turns a raster byte stream into padded
//            3 x (2*WIN_HALF+1) neighbourhood windows, one per grid cell.
// Config   : GEAR_WIN_STAR_COUNT_EN adds the star_cnt output and its counter.
// Revision : 1.0  initial release
// ============================================================================
module gear_window_buffer #(
  parameter int              WIDTH    = 8,
  parameter int              ROW_LEN  = 140,
  parameter int              NUM_ROWS = 140,
  parameter int              WIN_HALF = 3,
  parameter logic [WIDTH-1:0] PAD_CHAR = 8'h2E
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  input  logic [WIDTH-1:0]                       in_data,
  output logic                                   in_ready,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [3*(2*WIN_HALF+1)*WIDTH-1:0]      out_win,
  output logic [WIDTH-1:0]                       out_center,
  output logic [15:0]                            out_row,
  output logic [15:0]                            out_col,
  output logic                                   out_last,
  output logic                                   done
`ifdef GEAR_WIN_STAR_COUNT_EN
  ,
  output logic [31:0]                            star_cnt
`endif
);

  localparam int          WIN_COLS = 2 * WIN_HALF + 1;
  localparam int          DEPTH    = 3 * ROW_LEN;
  localparam int          ADDR_W   = $clog2(DEPTH);
  localparam int          SUM_W    = ADDR_W + 2;
  localparam logic [31:0] TOTAL    = 32'(ROW_LEN * NUM_ROWS);
  localparam logic [31:0] LAG_MAX  = 32'(ROW_LEN + WIN_HALF);

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         wcount_q, wcount_d;
  logic [31:0]         p_q, p_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   rptr_q, rptr_d;
  logic [15:0]         out_row_q, out_row_d;
  logic [15:0]         out_col_q, out_col_d;
  logic                done_q, done_d;
  logic [31:0]         lag;
  logic                in_fire;
  logic                out_fire;

  logic [WIDTH-1:0]    ring_q [DEPTH];

  always_comb begin
    lag       = wcount_q - p_q;
    in_ready  = (state_q == ST_STREAM) && (lag <= LAG_MAX);
    out_valid = (state_q != ST_DONE) && (wcount_q > p_q) &&
                ((lag >= LAG_MAX + 32'd1) || (wcount_q == TOTAL));
    out_last  = out_valid && (p_q == TOTAL - 32'd1);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  always_comb begin
    state_d   = state_q;
    wcount_d  = wcount_q;
    p_d       = p_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;

    if (in_fire) begin
      wcount_d = wcount_q + 32'd1;
      wptr_d   = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + ADDR_W'(1);
      if (wcount_q + 32'd1 == TOTAL) begin
        state_d = ST_DRAIN;
      end
    end

    if (out_fire) begin
      p_d    = p_q + 32'd1;
      rptr_d = (rptr_q == ADDR_W'(DEPTH - 1)) ? '0 : rptr_q + ADDR_W'(1);
      if (out_col_q == 16'(ROW_LEN - 1)) begin
        out_col_d = '0;
        out_row_d = out_row_q + 16'd1;
      end else begin
        out_col_d = out_col_q + 16'd1;
      end
      if (out_last) begin
        state_d = ST_DONE;
      end
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STREAM;
      wcount_q  <= '0;
      p_q       <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcount_q  <= wcount_d;
      p_q       <= p_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      done_q    <= done_d;
    end
  end

  // Ring contents survive reset; counter gating keeps stale bytes invisible.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      ring_q[wptr_q] <= in_data;
    end
  end

  genvar gr, gk;
  generate
    for (gr = 0; gr < 3; gr++) begin : g_row
      logic row_ok;

      if (gr == 0) begin : g_row_above
        assign row_ok = (out_row_q != 16'd0);
      end else if (gr == 2) begin : g_row_below
        assign row_ok = (out_row_q != 16'(NUM_ROWS - 1));
      end else begin : g_row_centre
        assign row_ok = 1'b1;
      end

      for (gk = 0; gk < WIN_COLS; gk++) begin : g_col
        // Offset is biased by DEPTH so the ring address never goes negative.
        localparam int OFS = DEPTH + (gr - 1) * ROW_LEN + (gk - WIN_HALF);

        logic [16:0]       col_sum;
        logic              col_ok;
        logic [SUM_W-1:0]  addr_sum;
        logic [ADDR_W-1:0] addr;

        assign col_sum  = {1'b0, out_col_q} + 17'(gk);
        assign col_ok   = (col_sum >= 17'(WIN_HALF)) &&
                          (col_sum <  17'(ROW_LEN + WIN_HALF));
        assign addr_sum = SUM_W'(rptr_q) + SUM_W'(OFS);

        always_comb begin
          if (addr_sum >= SUM_W'(2 * DEPTH)) begin
            addr = ADDR_W'(addr_sum - SUM_W'(2 * DEPTH));
          end else if (addr_sum >= SUM_W'(DEPTH)) begin
            addr = ADDR_W'(addr_sum - SUM_W'(DEPTH));
          end else begin
            addr = ADDR_W'(addr_sum);
          end
        end

        assign out_win[(gr*WIN_COLS+gk)*WIDTH +: WIDTH] =
          (row_ok && col_ok) ? ring_q[addr] : PAD_CHAR;
      end
    end
  endgenerate

  assign out_center = out_win[(WIN_COLS + WIN_HALF)*WIDTH +: WIDTH];
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign done       = done_q;

`ifdef GEAR_WIN_STAR_COUNT_EN
  logic [31:0] star_cnt_q, star_cnt_d;

  always_comb begin
    star_cnt_d = star_cnt_q;
    if (out_fire && (out_center == WIDTH'(8'h2A)) && (star_cnt_q != 32'hFFFF_FFFF)) begin
      star_cnt_d = star_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      star_cnt_q <= '0;
    end else begin
      star_cnt_q <= star_cnt_d;
    end
  end

  assign star_cnt = star_cnt_q;
`endif

endmodule
`default_nettype wire
